// File: rtl/ghost_mode_scheduler.sv
// Frame-rate ghost mode sequencer: scatter/chase phase timing, frightened/eyes tracking,
// and PacMan/ghost collision arbitration into eat and catch events.
module ghost_mode_scheduler #(
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120,
  parameter int NUM_PHASES     = 4,
  parameter int DEATH_FRAMES   = 90,
  parameter int CNT_W          = 12
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       pause,
  input  logic       power_pellet,
  input  logic [3:0] ghost_touch,
  input  logic [3:0] ghost_home,
  output logic [1:0] mode,
  output logic [2:0] phase,
  output logic [3:0] frightened,
  output logic [3:0] eyes,
  output logic       flash,
  output logic       reverse,
  output logic       eat_pulse,
  output logic [1:0] eat_combo,
  output logic       caught
);

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_SCATTER = 2'b01;
  localparam logic [1:0] MODE_CHASE   = 2'b10;
  localparam logic [1:0] MODE_DYING   = 2'b11;

  localparam logic [CNT_W-1:0] SCATTER_LOAD = CNT_W'(SCATTER_FRAMES - 1);
  localparam logic [CNT_W-1:0] CHASE_LOAD   = CNT_W'(CHASE_FRAMES - 1);
  localparam logic [CNT_W-1:0] FRIGHT_LOAD  = CNT_W'(FRIGHT_FRAMES - 1);
  localparam logic [CNT_W-1:0] DEATH_LOAD   = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] FLASH_LIMIT  = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [2:0]       LAST_PHASE   = 3'(NUM_PHASES - 1);

  logic [1:0]       mode_q, mode_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] phase_tmr_q, phase_tmr_d;
  logic [CNT_W-1:0] fright_tmr_q, fright_tmr_d;
  logic [CNT_W-1:0] death_tmr_q, death_tmr_d;
  logic             fright_act_q, fright_act_d;
  logic [3:0]       frightened_q, frightened_d;
  logic [3:0]       eyes_q, eyes_d;
  logic             flash_q, flash_d;
  logic             reverse_q, reverse_d;
  logic             eat_q, eat_d;
  logic [1:0]       eat_combo_q, eat_combo_d;
  logic             caught_q, caught_d;
  logic [1:0]       combo_q, combo_d;

  logic [3:0] touch_normal;
  logic [3:0] eat_cand;
  logic [3:0] eat_sel;

  // Collisions are judged against last frame's frightened/eyes, never this frame's pellet.
  assign touch_normal = ghost_touch & ~frightened_q & ~eyes_q;
  assign eat_cand     = ghost_touch & frightened_q & ~eyes_q;
  assign eat_sel      = eat_cand & (~eat_cand + 4'd1);

  always_comb begin
    mode_d       = mode_q;
    phase_d      = phase_q;
    phase_tmr_d  = phase_tmr_q;
    fright_tmr_d = fright_tmr_q;
    death_tmr_d  = death_tmr_q;
    fright_act_d = fright_act_q;
    frightened_d = frightened_q;
    eyes_d       = eyes_q;
    flash_d      = flash_q;
    combo_d      = combo_q;
    reverse_d    = reverse_q;
    eat_d        = eat_q;
    eat_combo_d  = eat_combo_q;
    caught_d     = caught_q;

    if (!pause) begin
      reverse_d   = 1'b0;
      eat_d       = 1'b0;
      eat_combo_d = 2'd0;
      caught_d    = 1'b0;

      case (mode_q)
        MODE_IDLE: begin
          if (start) begin
            mode_d      = MODE_SCATTER;
            phase_d     = 3'd0;
            phase_tmr_d = SCATTER_LOAD;
          end
        end

        MODE_SCATTER, MODE_CHASE: begin
          // A pellet frame also holds the phase timer, so it resumes at the value it showed.
          if (!fright_act_q) begin
            if (phase_tmr_q == CNT_ZERO) begin
              if (mode_q == MODE_SCATTER) begin
                mode_d      = MODE_CHASE;
                phase_tmr_d = CHASE_LOAD;
                reverse_d   = 1'b1;
              end else if (phase_q != LAST_PHASE) begin
                mode_d      = MODE_SCATTER;
                phase_d     = phase_q + 3'd1;
                phase_tmr_d = SCATTER_LOAD;
                reverse_d   = 1'b1;
              end
            end else if (!power_pellet) begin
              phase_tmr_d = phase_tmr_q - CNT_ONE;
            end
          end

          if (fright_act_q) begin
            if (fright_tmr_q == CNT_ZERO) begin
              fright_act_d = 1'b0;
              frightened_d = 4'd0;
            end else begin
              fright_tmr_d = fright_tmr_q - CNT_ONE;
            end
          end

          if (touch_normal == 4'd0 && eat_cand != 4'd0) begin
            frightened_d = frightened_d & ~eat_sel;
            eyes_d       = eyes_q | eat_sel;
            eat_d        = 1'b1;
            eat_combo_d  = combo_q;
            combo_d      = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
          end

          eyes_d = eyes_d & ~ghost_home;

          if (power_pellet) begin
            fright_tmr_d = FRIGHT_LOAD;
            fright_act_d = 1'b1;
            frightened_d = ~eyes_d;
            combo_d      = 2'd0;
            reverse_d    = 1'b1;
          end

          // A catch overrides every other event of the frame.
          if (touch_normal != 4'd0) begin
            mode_d       = MODE_DYING;
            death_tmr_d  = DEATH_LOAD;
            caught_d     = 1'b1;
            frightened_d = 4'd0;
            eyes_d       = 4'd0;
            fright_act_d = 1'b0;
            fright_tmr_d = CNT_ZERO;
            combo_d      = 2'd0;
            reverse_d    = 1'b0;
            eat_d        = 1'b0;
            eat_combo_d  = 2'd0;
          end
        end

        MODE_DYING: begin
          if (death_tmr_q == CNT_ZERO) begin
            mode_d       = MODE_IDLE;
            phase_d      = 3'd0;
            phase_tmr_d  = CNT_ZERO;
            fright_tmr_d = CNT_ZERO;
          end else begin
            death_tmr_d = death_tmr_q - CNT_ONE;
          end
        end

        default: mode_d = MODE_IDLE;
      endcase

      flash_d = fright_act_d && (fright_tmr_d < FLASH_LIMIT);
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      mode_q       <= MODE_IDLE;
      phase_q      <= 3'd0;
      phase_tmr_q  <= CNT_ZERO;
      fright_tmr_q <= CNT_ZERO;
      death_tmr_q  <= CNT_ZERO;
      fright_act_q <= 1'b0;
      frightened_q <= 4'd0;
      eyes_q       <= 4'd0;
      flash_q      <= 1'b0;
      combo_q      <= 2'd0;
      reverse_q    <= 1'b0;
      eat_q        <= 1'b0;
      eat_combo_q  <= 2'd0;
      caught_q     <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      phase_tmr_q  <= phase_tmr_d;
      fright_tmr_q <= fright_tmr_d;
      death_tmr_q  <= death_tmr_d;
      fright_act_q <= fright_act_d;
      frightened_q <= frightened_d;
      eyes_q       <= eyes_d;
      flash_q      <= flash_d;
      combo_q      <= combo_d;
      reverse_q    <= reverse_d;
      eat_q        <= eat_d;
      eat_combo_q  <= eat_combo_d;
      caught_q     <= caught_d;
    end
  end

  assign mode       = mode_q;
  assign phase      = phase_q;
  assign frightened = frightened_q;
  assign eyes       = eyes_q;
  assign flash      = flash_q;
  assign reverse    = reverse_q;
  assign eat_pulse  = eat_q;
  assign eat_combo  = eat_combo_q;
  assign caught     = caught_q;

endmodule
